uart_param: RTL and testbench
=============================

# uart_param

Parametrised full-duplex UART with runtime baud divisor, configurable data width, optional parity and one or two stop bits. It replaces the fixed-rate 8N1 UART at the host/debug link of the filter datapath. It gives ready/valid byte streams on both sides, plus per-frame error status.

## Interface

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- DIV_WIDTH, 16, width of the baud divisor input.
- SYNC_DEPTH, 2, rx synchroniser flops; must be at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous assert, active-low. Released synchronously to clk upstream.
- baud_div  in  DIV_WIDTH  clk cycles per bit. Values below 4 are treated as 4.
- parity_mode  in  2  parity select: 00 none, 01 even, 10 odd, 11 none.
- two_stop  in  1  1 = two stop bits on tx. Rx always checks only the first stop bit.
- rx  in  1  serial input, asynchronous.
- read_data  out  DATA_BITS  received word, LSB first on the line.
- read_valid  out  1  read_data and error flags are valid.
- read_ready  in  1  consumer accepts the word.
- parity_error  out  1  parity mismatch for the held word.
- framing_error  out  1  first stop bit was sampled 0 for the held word.
- overrun  out  1  one-cycle pulse: a frame completed while read_valid was high.
- tx  out  1  serial output.
- write_data  in  DATA_BITS  word to send.
- write_valid  in  1  producer offers write_data.
- write_ready  out  1  transmitter can accept a word.

## Operation

Reset values: tx=1, write_ready=0, read_valid=0, read_data=0, all error flags=0. Both FSMs return to IDLE on reset.

- Config sampling: baud_div, parity_mode and two_stop are latched when a frame starts (tx accept or rx start detect). Changes mid-frame have no effect on the current frame.
- TX FSM: IDLE -> START -> DATA -> PARITY (only if parity is enabled) -> STOP1 -> STOP2 (only if two_stop) -> IDLE.
  - In IDLE, write_ready=1. A word is accepted on a cycle where write_valid && write_ready.
  - write_data is copied to a shift register on accept.
  - Bit period is the latched divisor. Data is sent LSB first.
  - Even parity: the parity bit makes the total count of 1s (data plus parity) even. Odd parity makes it odd.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
  - A start is detected on a 1->0 transition at the synchroniser output.
  - START: the line is re-checked at half a bit period. If it reads 1, this is a false start and the FSM returns to IDLE with no output.
  - Each later bit is the majority vote of 3 samples, taken at counter positions div/2-1, div/2 and div/2+1 from the bit start.
  - The FSM returns to IDLE after the stop-bit centre sample. This allows back-to-back frames with no idle gap.
- RX output register:
  - At the stop-bit centre, if read_valid=0: load read_data, parity_error and framing_error, and set read_valid.
  - If read_valid=1 at that point: the new frame is discarded, the held word is kept, and overrun pulses.
  - read_valid clears on the cycle after read_valid && read_ready.
  - When a word is loaded and the previous word is consumed in the same cycle, the load wins and read_valid stays 1.
- Frames with a framing error or parity error are still delivered, with the matching flag set.
- Bit and cycle counters are sized as $clog2(DATA_BITS+1) and DIV_WIDTH bits. No counter wraps inside a frame.

## Timing

- Accept to start bit: tx falls on the clock edge after the accept cycle. write_ready drops on that same edge.
- Frame length on the line: (1 + DATA_BITS + P + S) × div cycles, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
- write_ready rises on the edge that ends the last stop bit. A new accept in that cycle starts the next frame with no gap.
- RX latency: read_valid rises (SYNC_DEPTH + 1) cycles after the stop-bit centre on the pin.
- Reset mid-frame: tx goes to 1 immediately (asynchronously). No partial word is ever presented.

## Configuration

- UART_PARITY_EN: when defined, the PARITY states, parity generation and parity checking are compiled in.
- When not defined:
  - parity_mode is ignored and frames never contain a parity bit.
  - parity_error is tied to 0.
  - The PARITY states do not exist.

## Test plan

- Reset with rst_n held low for 5 cycles -> tx=1, write_ready=0, read_valid=0. One cycle after release -> write_ready=1.
- TX with div=8, no parity, one stop, write_data=0xA5 -> line bits 0,1,0,1,0,0,1,0,1,1, each 8 cycles, 80 cycles total. write_ready returns at cycle 80.
- Loopback (tx wired to rx), div=8, even parity, two_stop=1, 0x07 -> parity bit is 1, frame is 96 cycles. read_data=0x07 with no error flags.
- RX stop bit forced to 0 on 0x3C -> read_valid=1, read_data=0x3C, framing_error=1. A 2-cycle low glitch on an idle line -> no read_valid.
- Two frames received with read_ready=0 -> first word held, overrun pulses once. After read_ready=1 -> read_valid clears the next cycle.
- rst_n asserted in the middle of the TX data bits -> tx=1 immediately. After release, the next accept sends a clean frame.

Source files
------------

// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART with a runtime baud divisor,
// DATA_BITS-wide words, one or two transmit stop bits and per-frame status.
// Optional feature macro: UART_PARITY_EN compiles in parity generation and checking.
module uart_param #(
  parameter int DATA_BITS  = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int SYNC_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] read_data,
  output logic                 read_valid,
  input  logic                 read_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] write_data,
  input  logic                 write_valid,
  output logic                 write_ready
);
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_STOP1 = 3'd3, TX_STOP2 = 3'd4
`ifdef UART_PARITY_EN
    , TX_PARITY = 3'd5
`endif
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3
`ifdef UART_PARITY_EN
    , RX_PARITY = 3'd4
`endif
  } rx_state_t;

  // Parity bit for a word: even mode when odd=0, odd mode when odd=1.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // Majority of three samples.
  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Divisors below 4 leave no room for the three-sample vote, so clamp them.
  function automatic logic [DIV_WIDTH-1:0] eff_div(input logic [DIV_WIDTH-1:0] d);
    return (d < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : d;
  endfunction

`ifdef UART_PARITY_EN
  logic par_en_s;
  assign par_en_s = (parity_mode == 2'b01) || (parity_mode == 2'b10);
  logic tx_par_en_r, tx_par_r, rx_par_en_r, rx_odd_r, rx_perr_r;
`else
  logic unused_parity_s;
  assign unused_parity_s = ^parity_mode;
  assign parity_error    = 1'b0;
`endif

  // ---------------- transmitter ----------------
  tx_state_t            tx_state_r;
  logic [DIV_WIDTH-1:0] tx_cnt_r, tx_div_r;
  logic [BW-1:0]        tx_bit_r;
  logic [DATA_BITS-1:0] tx_shift_r;
  logic                 tx_two_r;

  // TX FSM: latches config on accept, then walks the frame one bit period at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r  <= TX_IDLE;
      tx          <= 1'b1;
      write_ready <= 1'b0;
      tx_cnt_r    <= '0;
      tx_div_r    <= DIV_WIDTH'(4);
      tx_bit_r    <= '0;
      tx_shift_r  <= '0;
      tx_two_r    <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_en_r <= 1'b0;
      tx_par_r    <= 1'b0;
`endif
    end else if (tx_state_r == TX_IDLE) begin
      if (write_valid && write_ready) begin
        tx_state_r  <= TX_START;
        tx          <= 1'b0;
        write_ready <= 1'b0;
        tx_cnt_r    <= '0;
        tx_bit_r    <= '0;
        tx_shift_r  <= write_data;
        tx_div_r    <= eff_div(baud_div);
        tx_two_r    <= two_stop;
`ifdef UART_PARITY_EN
        tx_par_en_r <= par_en_s;
        tx_par_r    <= parity_bit(write_data, parity_mode[1]);
`endif
      end else begin
        tx          <= 1'b1;
        write_ready <= 1'b1;
      end
    end else if (tx_cnt_r == tx_div_r - DIV_WIDTH'(1)) begin
      tx_cnt_r <= '0;
      case (tx_state_r)
        TX_START: begin
          tx_state_r <= TX_DATA;
          tx         <= tx_shift_r[0];
        end
        TX_DATA: begin
          if (tx_bit_r == BW'(DATA_BITS - 1)) begin
            tx_state_r <= TX_STOP1;
            tx         <= 1'b1;
`ifdef UART_PARITY_EN
            if (tx_par_en_r) begin
              tx_state_r <= TX_PARITY;
              tx         <= tx_par_r;
            end
`endif
          end else begin
            tx_bit_r   <= tx_bit_r + BW'(1);
            tx_shift_r <= tx_shift_r >> 1;
            tx         <= tx_shift_r[1];
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          tx_state_r <= TX_STOP1;
          tx         <= 1'b1;
        end
`endif
        TX_STOP1: begin
          if (tx_two_r) begin
            tx_state_r <= TX_STOP2;
          end else begin
            tx_state_r  <= TX_IDLE;
            write_ready <= 1'b1;
          end
        end
        TX_STOP2: begin
          tx_state_r  <= TX_IDLE;
          write_ready <= 1'b1;
        end
        default: begin
          tx_state_r <= TX_IDLE;
          tx         <= 1'b1;
        end
      endcase
    end else begin
      tx_cnt_r <= tx_cnt_r + DIV_WIDTH'(1);
    end
  end

  // ---------------- receiver ----------------
  logic [SYNC_DEPTH-1:0] sync_r;
  logic                  rx_s, rx_prev_r;

  // Synchroniser for the asynchronous line plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r    <= '1;
      rx_prev_r <= 1'b1;
    end else begin
      sync_r    <= {sync_r[SYNC_DEPTH-2:0], rx};
      rx_prev_r <= rx_s;
    end
  end
  assign rx_s = sync_r[SYNC_DEPTH-1];

  rx_state_t            rx_state_r;
  logic [DIV_WIDTH-1:0] rx_cnt_r, rx_div_r, rx_half_r;
  logic [BW-1:0]        rx_bit_r;
  logic [DATA_BITS-1:0] rx_shift_r;
  logic [1:0]           rx_vote_r;
  logic                 rx_sample_s, at_h1_s, at_end_s;

  assign rx_sample_s = vote3(rx_vote_r[0], rx_vote_r[1], rx_s);
  assign at_h1_s     = (rx_cnt_r == rx_half_r + DIV_WIDTH'(1));
  assign at_end_s    = (rx_cnt_r == rx_div_r - DIV_WIDTH'(1));

  // RX FSM and output holding register with overrun detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r    <= RX_IDLE;
      rx_cnt_r      <= DIV_WIDTH'(1);
      rx_div_r      <= DIV_WIDTH'(4);
      rx_half_r     <= DIV_WIDTH'(2);
      rx_bit_r      <= '0;
      rx_shift_r    <= '0;
      rx_vote_r     <= 2'b11;
      read_data     <= '0;
      read_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_en_r   <= 1'b0;
      rx_odd_r      <= 1'b0;
      rx_perr_r     <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;
      if (read_valid && read_ready) read_valid <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          // Detect cycle is bit position 0, so START begins at position 1.
          rx_cnt_r <= DIV_WIDTH'(1);
          if (rx_prev_r && !rx_s) begin
            rx_state_r <= RX_START;
            rx_div_r   <= eff_div(baud_div);
            rx_half_r  <= eff_div(baud_div) >> 1;
`ifdef UART_PARITY_EN
            rx_par_en_r <= par_en_s;
            rx_odd_r    <= parity_mode[1];
            rx_perr_r   <= 1'b0;
`endif
          end
        end
        RX_START: begin
          if ((rx_cnt_r == rx_half_r) && rx_s) begin
            rx_state_r <= RX_IDLE;
          end else if (at_end_s) begin
            rx_cnt_r   <= '0;
            rx_bit_r   <= '0;
            rx_state_r <= RX_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + DIV_WIDTH'(1);
          end
        end
        default: begin
          if (rx_cnt_r == rx_half_r - DIV_WIDTH'(1)) rx_vote_r[0] <= rx_s;
          if (rx_cnt_r == rx_half_r) rx_vote_r[1] <= rx_s;
          rx_cnt_r <= at_end_s ? '0 : rx_cnt_r + DIV_WIDTH'(1);
          case (rx_state_r)
            RX_DATA: begin
              if (at_h1_s) rx_shift_r <= {rx_sample_s, rx_shift_r[DATA_BITS-1:1]};
              if (at_end_s) begin
                if (rx_bit_r == BW'(DATA_BITS - 1)) begin
                  rx_state_r <= RX_STOP;
`ifdef UART_PARITY_EN
                  if (rx_par_en_r) rx_state_r <= RX_PARITY;
`endif
                end else begin
                  rx_bit_r <= rx_bit_r + BW'(1);
                end
              end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
              if (at_h1_s) rx_perr_r <= rx_sample_s ^ parity_bit(rx_shift_r, rx_odd_r);
              if (at_end_s) rx_state_r <= RX_STOP;
            end
`endif
            RX_STOP: begin
              // Leave at the stop centre so a back-to-back start edge is not missed.
              if (at_h1_s) begin
                rx_state_r <= RX_IDLE;
                if (read_valid && !read_ready) begin
                  overrun <= 1'b1;
                end else begin
                  read_valid    <= 1'b1;
                  read_data     <= rx_shift_r;
                  framing_error <= !rx_sample_s;
`ifdef UART_PARITY_EN
                  parity_error  <= rx_perr_r;
`endif
                end
              end
            end
            default: rx_state_r <= RX_IDLE;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: randomized self-checking bench for uart_param. Expected line
// bits and received words come from a frame-level model built from the rules.
module tb_uart_param;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   baud_div;
  logic [1:0]    parity_mode;
  logic          two_stop;
  logic          rx_drv, loop_en, rx_line;
  logic [DB-1:0] read_data, write_data;
  logic          read_valid, read_ready, parity_error, framing_error, overrun;
  logic          tx, write_valid, write_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int ov_cnt   = 0;
  bit frame_q[$];

  always #5 clk = ~clk;
  assign rx_line = loop_en ? tx : rx_drv;

  uart_param #(.DATA_BITS(DB), .DIV_WIDTH(16), .SYNC_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode),
    .two_stop(two_stop), .rx(rx_line), .read_data(read_data), .read_valid(read_valid),
    .read_ready(read_ready), .parity_error(parity_error), .framing_error(framing_error),
    .overrun(overrun), .tx(tx), .write_data(write_data), .write_valid(write_valid),
    .write_ready(write_ready)
  );

  // Count overrun pulses away from the active edge.
  always @(negedge clk) if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int eff(input int d);
    return (d < 4) ? 4 : d;
  endfunction

  function automatic bit par_on(input logic [1:0] m);
`ifdef UART_PARITY_EN
    return (m == 2'b01) || (m == 2'b10);
`else
    return 1'b0;
`endif
  endfunction

  // Reference frame: start, data LSB first, optional parity, stop(s).
  task automatic build_frame(input logic [DB-1:0] d, input logic [1:0] m, input bit two,
                             input bit stop_val, input bit flip_par);
    int ones;
    ones = $countones(d);
    frame_q.delete();
    frame_q.push_back(1'b0);
    for (int i = 0; i < DB; i++) frame_q.push_back(d[i]);
    if (par_on(m)) begin
      if (m == 2'b01) frame_q.push_back(bit'(ones % 2) ^ flip_par);
      else            frame_q.push_back(bit'((ones + 1) % 2) ^ flip_par);
    end
    frame_q.push_back(stop_val);
    if (two) frame_q.push_back(1'b1);
  endtask

  // Send one word and check every line bit at its centre plus write_ready timing.
  task automatic tx_check(input logic [DB-1:0] d, input int div, input logic [1:0] m,
                          input bit two, input bit mutate);
    int e, cur, tgt, total;
    e = eff(div);
    @(posedge clk); #1;
    baud_div = 16'(div); parity_mode = m; two_stop = two;
    write_data = d; write_valid = 1'b1;
    build_frame(d, m, two, 1'b1, 1'b0);
    @(posedge clk); #1;
    write_valid = 1'b0;
    write_data  = DB'($urandom);
    if (mutate) begin
      baud_div    = 16'($urandom_range(2, 20));
      parity_mode = 2'($urandom_range(0, 3));
      two_stop    = 1'($urandom_range(0, 1));
    end
    cur = -1;
    for (int b = 0; b < frame_q.size(); b++) begin
      tgt = b * e + e / 2;
      repeat (tgt - cur) @(negedge clk);
      cur = tgt;
      check($sformatf("tx_bit%0d", b), 32'(tx), 32'(frame_q[b]));
    end
    total = frame_q.size() * e;
    repeat (total - 1 - cur) @(negedge clk);
    check("tx_ready_busy", 32'(write_ready), 32'd0);
    @(negedge clk);
    check("tx_ready_back", 32'(write_ready), 32'd1);
  endtask

  // Drive a frame on rx from the model, each bit held for the effective divisor.
  task automatic rx_send(input logic [DB-1:0] d, input int div, input logic [1:0] m,
                         input bit two, input bit stop_val, input bit flip);
    int e;
    e = eff(div);
    baud_div = 16'(div); parity_mode = m; two_stop = two;
    build_frame(d, m, two, stop_val, flip);
    foreach (frame_q[i]) begin
      @(posedge clk); #1 rx_drv = frame_q[i];
      repeat (e - 1) @(posedge clk);
    end
    @(posedge clk); #1 rx_drv = 1'b1;
    repeat (e + 6) @(posedge clk);
  endtask

  // Check the held word and flags, then consume it.
  task automatic rx_expect(input logic [DB-1:0] d, input bit fe, input bit pe);
    @(negedge clk);
    check("rx_valid", 32'(read_valid), 32'd1);
    check("rx_data", 32'(read_data), 32'(d));
    check("rx_frame_err", 32'(framing_error), 32'(fe));
    check("rx_parity_err", 32'(parity_error), 32'(pe));
    @(posedge clk); #1 read_ready = 1'b1;
    @(posedge clk); #1 read_ready = 1'b0;
    @(negedge clk);
    check("rx_consumed", 32'(read_valid), 32'd0);
  endtask

  initial begin
    logic [DB-1:0] d;
    logic [1:0]    m;
    bit            two, stop_v, flip;
    int            div, ov0;

    rst_n = 1'b0; baud_div = 16'd8; parity_mode = 2'b00; two_stop = 1'b0;
    rx_drv = 1'b1; loop_en = 1'b0; read_ready = 1'b0;
    write_data = '0; write_valid = 1'b0;

    // Reset state and write_ready one cycle after release.
    repeat (5) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_write_ready", 32'(write_ready), 32'd0);
    check("rst_read_valid", 32'(read_valid), 32'd0);
    check("rst_read_data", 32'(read_data), 32'd0);
    check("rst_framing", 32'(framing_error), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_write_ready", 32'(write_ready), 32'd1);

    // Directed TX frame 0xA5, div 8, 8N1.
    tx_check(8'hA5, 8, 2'b00, 1'b0, 1'b1);

    // Loopback 0x07 with even parity and two stop bits.
    loop_en = 1'b1;
    tx_check(8'h07, 8, 2'b01, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    rx_expect(8'h07, 1'b0, 1'b0);
    loop_en = 1'b0;

    // Stop bit forced low.
    rx_send(8'h3C, 8, 2'b00, 1'b0, 1'b0, 1'b0);
    rx_expect(8'h3C, 1'b1, 1'b0);

    // Short low glitch on an idle line is a false start.
    baud_div = 16'd8;
    @(posedge clk); #1 rx_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("glitch_no_valid", 32'(read_valid), 32'd0);

    // Two frames without consuming: first held, one overrun pulse.
    ov0 = ov_cnt;
    rx_send(8'h11, 6, 2'b00, 1'b0, 1'b1, 1'b0);
    rx_send(8'h22, 6, 2'b00, 1'b0, 1'b1, 1'b0);
    @(negedge clk); #1;
    check("overrun_pulses", 32'(ov_cnt - ov0), 32'd1);
    rx_expect(8'h11, 1'b0, 1'b0);

    // Reset in the middle of data bits of an all-zero word.
    @(posedge clk); #1;
    baud_div = 16'd8; parity_mode = 2'b00; two_stop = 1'b0;
    write_data = 8'h00; write_valid = 1'b1;
    @(posedge clk); #1 write_valid = 1'b0;
    repeat (30) @(posedge clk);
    #2 check("pre_reset_tx", 32'(tx), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_reset_tx", 32'(tx), 32'd1);
    check("mid_reset_ready", 32'(write_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tx_check(DB'($urandom), 8, 2'b00, 1'b0, 1'b1);

    // Randomized TX frames, including divisors below 4 and mid-frame config changes.
    for (int k = 0; k < 6; k++) begin
      tx_check(DB'($urandom), $urandom_range(2, 11), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'b1);
    end

    // Randomized RX frames with occasional bad stop bit or flipped parity.
    for (int k = 0; k < 6; k++) begin
      d      = DB'($urandom);
      div    = $urandom_range(2, 11);
      m      = 2'($urandom_range(0, 3));
      two    = 1'($urandom_range(0, 1));
      stop_v = ($urandom_range(0, 3) != 0);
      flip   = 1'($urandom_range(0, 1));
      rx_send(d, div, m, two, stop_v, flip);
      rx_expect(d, !stop_v, par_on(m) && flip);
    end

    // Randomized loopback.
    loop_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = DB'($urandom);
      tx_check(d, $urandom_range(4, 10), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      repeat (6) @(negedge clk);
      rx_expect(d, 1'b0, 1'b0);
    end
    loop_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
